simd_salu: RTL and testbench



---
 rtl/simd_salu.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_simd_salu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_salu.sv
// Scalar ALU slice of the SIMD compute unit: accepts SOP2 instructions, runs them through
// a three-stage accept/execute/writeback pipeline with full bypassing, and updates SGPRs/SCC.
module simd_salu #(
   parameter int INSTR_SIZE = 32,
   parameter int NUM_SGPR   = 106
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  icache_rd_resp_valid,
   output logic                  icache_rd_resp_ready,
   input  logic [INSTR_SIZE-1:0] icache_rd_resp_data,
   output logic                  wb_valid,
   output logic [6:0]            wb_dest,
   output logic [31:0]           wb_data,
   output logic                  wb_scc,
   output logic                  illegal_instr
);

   localparam logic [7:0] SRC_LIMIT  = 8'(NUM_SGPR);
   localparam logic [6:0] DEST_LIMIT = 7'(NUM_SGPR);

   localparam logic [6:0] OP_ADD_U32  = 7'd0;
   localparam logic [6:0] OP_SUB_U32  = 7'd1;
   localparam logic [6:0] OP_ADD_I32  = 7'd2;
   localparam logic [6:0] OP_SUB_I32  = 7'd3;
   localparam logic [6:0] OP_ADDC_U32 = 7'd4;
   localparam logic [6:0] OP_SUBB_U32 = 7'd5;
   localparam logic [6:0] OP_MIN_I32  = 7'd6;
   localparam logic [6:0] OP_MIN_U32  = 7'd7;
   localparam logic [6:0] OP_MAX_I32  = 7'd8;
   localparam logic [6:0] OP_MAX_U32  = 7'd9;
   localparam logic [6:0] OP_CSELECT  = 7'd10;
   localparam logic [6:0] OP_AND      = 7'd14;
   localparam logic [6:0] OP_OR       = 7'd16;
   localparam logic [6:0] OP_XOR      = 7'd18;
   localparam logic [6:0] OP_LSHL     = 7'd30;
   localparam logic [6:0] OP_LSHR     = 7'd32;
   localparam logic [6:0] OP_ASHR     = 7'd34;
   localparam logic [6:0] OP_MUL_I32  = 7'd36;

   logic        ex_valid_r;
   logic [31:0] ex_instr_r;
   logic        wb_valid_r;
   logic [6:0]  wb_dest_r;
   logic [31:0] wb_data_r;
   logic        wb_scc_r;
   logic        illegal_r;
   logic [31:0] sgpr_r [NUM_SGPR];
   logic        scc_r;

   logic        accept_s;
   logic [7:0]  src0_code_s;
   logic [7:0]  src1_code_s;
   logic [6:0]  opcode_s;
   logic        scc_in_s;
   logic [31:0] sgpr0_s;
   logic [31:0] sgpr1_s;
   logic [31:0] op_a_s;
   logic [31:0] op_b_s;
   logic [32:0] sum_s;
   logic [31:0] res_s;
   logic        scc_out_s;
   logic        pick_a_s;
   logic        legal_s;

   // Maps an 8-bit operand code onto its 32-bit value; sgpr_val is the already-bypassed SGPR read.
   function automatic logic [31:0] decode_operand(input logic [7:0] code,
                                                  input logic [31:0] sgpr_val,
                                                  input logic scc_val);
      logic [31:0] val;
      if (code < SRC_LIMIT) begin
         val = sgpr_val;
      end else if ((code >= 8'd128) && (code <= 8'd192)) begin
         val = {24'd0, code - 8'd128};
      end else if ((code >= 8'd193) && (code <= 8'd208)) begin
         val = 32'd192 - {24'd0, code};
      end else if (code == 8'd253) begin
         val = {31'd0, scc_val};
      end else begin
         val = 32'd0;
      end
      return val;
   endfunction

   // Ready follows reset directly so it drops exactly while rst_n is low.
   assign icache_rd_resp_ready = rst_n;
   assign accept_s             = icache_rd_resp_valid && icache_rd_resp_ready;

   assign src0_code_s = ex_instr_r[7:0];
   assign src1_code_s = ex_instr_r[15:8];
   assign opcode_s    = ex_instr_r[29:23];

   // Accept stage: capture the instruction on a valid/ready handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_r <= 1'b0;
         ex_instr_r <= 32'd0;
      end else begin
         ex_valid_r <= accept_s;
         if (accept_s) begin
            ex_instr_r <= icache_rd_resp_data[31:0];
         end else begin
            ex_instr_r <= ex_instr_r;
         end
      end
   end

   // Operand fetch, bypassing the writeback stage for SGPRs and SCC.
   always_comb begin
      scc_in_s = scc_r;
      sgpr0_s  = 32'd0;
      sgpr1_s  = 32'd0;
      if (wb_valid_r) begin
         scc_in_s = wb_scc_r;
      end else begin
         scc_in_s = scc_r;
      end
      if (src0_code_s < SRC_LIMIT) begin
         if (wb_valid_r && ({1'b0, wb_dest_r} == src0_code_s)) begin
            sgpr0_s = wb_data_r;
         end else begin
            sgpr0_s = sgpr_r[src0_code_s[6:0]];
         end
      end else begin
         sgpr0_s = 32'd0;
      end
      if (src1_code_s < SRC_LIMIT) begin
         if (wb_valid_r && ({1'b0, wb_dest_r} == src1_code_s)) begin
            sgpr1_s = wb_data_r;
         end else begin
            sgpr1_s = sgpr_r[src1_code_s[6:0]];
         end
      end else begin
         sgpr1_s = 32'd0;
      end
      op_a_s = decode_operand(src0_code_s, sgpr0_s, scc_in_s);
      op_b_s = decode_operand(src1_code_s, sgpr1_s, scc_in_s);
   end

   // Execute: compute result and the SCC value that holds after the instruction.
   always_comb begin
      sum_s     = 33'd0;
      res_s     = 32'd0;
      scc_out_s = scc_in_s;
      pick_a_s  = 1'b0;
      legal_s   = 1'b0;
      if (ex_instr_r[31:30] == 2'b10) begin
         legal_s = 1'b1;
         case (opcode_s)
            OP_ADD_U32: begin
               sum_s     = {1'b0, op_a_s} + {1'b0, op_b_s};
               res_s     = sum_s[31:0];
               scc_out_s = sum_s[32];
            end
            OP_SUB_U32: begin
               sum_s     = {1'b0, op_a_s} - {1'b0, op_b_s};
               res_s     = sum_s[31:0];
               scc_out_s = sum_s[32];
            end
            OP_ADD_I32: begin
               res_s     = op_a_s + op_b_s;
               scc_out_s = (op_a_s[31] == op_b_s[31]) && (res_s[31] != op_a_s[31]);
            end
            OP_SUB_I32: begin
               res_s     = op_a_s - op_b_s;
               scc_out_s = (op_a_s[31] != op_b_s[31]) && (res_s[31] != op_a_s[31]);
            end
            OP_ADDC_U32: begin
               sum_s     = {1'b0, op_a_s} + {1'b0, op_b_s} + {32'd0, scc_in_s};
               res_s     = sum_s[31:0];
               scc_out_s = sum_s[32];
            end
            OP_SUBB_U32: begin
               // Any negative difference lands with bit 32 set in 33-bit wraparound.
               sum_s     = {1'b0, op_a_s} - {1'b0, op_b_s} - {32'd0, scc_in_s};
               res_s     = sum_s[31:0];
               scc_out_s = sum_s[32];
            end
            OP_MIN_I32: begin
               pick_a_s  = $signed(op_a_s) <= $signed(op_b_s);
               res_s     = pick_a_s ? op_a_s : op_b_s;
               scc_out_s = pick_a_s;
            end
            OP_MIN_U32: begin
               pick_a_s  = op_a_s <= op_b_s;
               res_s     = pick_a_s ? op_a_s : op_b_s;
               scc_out_s = pick_a_s;
            end
            OP_MAX_I32: begin
               pick_a_s  = $signed(op_a_s) >= $signed(op_b_s);
               res_s     = pick_a_s ? op_a_s : op_b_s;
               scc_out_s = pick_a_s;
            end
            OP_MAX_U32: begin
               pick_a_s  = op_a_s >= op_b_s;
               res_s     = pick_a_s ? op_a_s : op_b_s;
               scc_out_s = pick_a_s;
            end
            OP_CSELECT: begin
               res_s = scc_in_s ? op_a_s : op_b_s;
            end
            OP_AND: begin
               res_s     = op_a_s & op_b_s;
               scc_out_s = |res_s;
            end
            OP_OR: begin
               res_s     = op_a_s | op_b_s;
               scc_out_s = |res_s;
            end
            OP_XOR: begin
               res_s     = op_a_s ^ op_b_s;
               scc_out_s = |res_s;
            end
            OP_LSHL: begin
               res_s     = op_a_s << op_b_s[4:0];
               scc_out_s = |res_s;
            end
            OP_LSHR: begin
               res_s     = op_a_s >> op_b_s[4:0];
               scc_out_s = |res_s;
            end
            OP_ASHR: begin
               res_s     = $signed(op_a_s) >>> op_b_s[4:0];
               scc_out_s = |res_s;
            end
            OP_MUL_I32: begin
               res_s = op_a_s * op_b_s;
            end
            default: begin
               legal_s = 1'b0;
            end
         endcase
      end else begin
         legal_s = 1'b0;
      end
   end

   // Writeback stage register; these drive the wb_* outputs directly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid_r <= 1'b0;
         wb_dest_r  <= 7'd0;
         wb_data_r  <= 32'd0;
         wb_scc_r   <= 1'b0;
         illegal_r  <= 1'b0;
      end else begin
         wb_valid_r <= ex_valid_r && legal_s;
         illegal_r  <= ex_valid_r && !legal_s;
         if (ex_valid_r && legal_s) begin
            wb_dest_r <= ex_instr_r[22:16];
            wb_data_r <= res_s;
            wb_scc_r  <= scc_out_s;
         end else begin
            wb_dest_r <= wb_dest_r;
            wb_data_r <= wb_data_r;
            wb_scc_r  <= wb_scc_r;
         end
      end
   end

   // Architectural state commit; destinations past the register file are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SGPR; i++) begin
            sgpr_r[i] <= 32'(i);
         end
         scc_r <= 1'b0;
      end else if (wb_valid_r) begin
         if (wb_dest_r < DEST_LIMIT) begin
            sgpr_r[wb_dest_r] <= wb_data_r;
         end
         scc_r <= wb_scc_r;
      end
   end

   assign wb_valid      = wb_valid_r;
   assign wb_dest       = wb_dest_r;
   assign wb_data       = wb_data_r;
   assign wb_scc        = wb_scc_r;
   assign illegal_instr = illegal_r;

endmodule

// File: tb/tb_simd_salu.sv
// Bench for simd_salu: directed spec scenarios plus random instruction streams scored
// against a sequential architectural model of the SGPR file and SCC.
module tb_simd_salu;

   localparam int NUM_SGPR = 106;
   localparam longint I32_MAX = 64'sd2147483647;
   localparam longint I32_MIN = -64'sd2147483648;
   localparam longint U32_MAX = 64'sd4294967295;
   localparam int LEGAL_OPS [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 14, 16, 18, 30, 32, 34, 36};

   typedef struct {
      logic        v;
      logic        ill;
      logic [6:0]  dest;
      logic [31:0] data;
      logic        scc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        wb_valid;
   logic [6:0]  wb_dest;
   logic [31:0] wb_data;
   logic        wb_scc;
   logic        illegal_instr;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] m_sgpr [NUM_SGPR];
   logic        m_scc;
   exp_t        pend;

   always #5 clk = ~clk;

   simd_salu dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .icache_rd_resp_valid (in_valid),
      .icache_rd_resp_ready (in_ready),
      .icache_rd_resp_data  (in_data),
      .wb_valid             (wb_valid),
      .wb_dest              (wb_dest),
      .wb_data              (wb_data),
      .wb_scc               (wb_scc),
      .illegal_instr        (illegal_instr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] enc(input logic [1:0] t, input int op, input int dest,
                                       input int s1, input int s0);
      return {t, 7'(op), 7'(dest), 8'(s1), 8'(s0)};
   endfunction

   function automatic exp_t idle_exp();
      exp_t e;
      e.v = 1'b0; e.ill = 1'b0; e.dest = 7'd0; e.data = 32'd0; e.scc = 1'b0;
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_SGPR; i++) m_sgpr[i] = 32'(i);
      m_scc = 1'b0;
      pend  = idle_exp();
   endtask

   function automatic logic [31:0] m_operand(input int code);
      if (code < NUM_SGPR) return m_sgpr[code];
      if (code >= 128 && code <= 192) return 32'(code - 128);
      if (code >= 193 && code <= 208) return 32'(192 - code);
      if (code == 253) return {31'd0, m_scc};
      return 32'd0;
   endfunction

   // Sequential reference: each instruction sees all earlier results, as the ISA defines.
   task automatic model_exec(input logic [31:0] ins, output exp_t e);
      int          op, dest;
      logic [31:0] a, b, r;
      longint      ua, ub, sa, sb, full;
      logic        c, legal;
      op = int'(ins[29:23]);
      dest = int'(ins[22:16]);
      a = m_operand(int'(ins[7:0]));
      b = m_operand(int'(ins[15:8]));
      ua = longint'(a); ub = longint'(b);
      sa = longint'(int'(a)); sb = longint'(int'(b));
      r = 32'd0; c = m_scc; legal = 1'b1; full = 0;
      case (op)
         0:  begin full = ua + ub; r = 32'(full); c = full > U32_MAX; end
         1:  begin r = 32'(ua - ub); c = ua < ub; end
         2:  begin full = sa + sb; r = 32'(full); c = (full > I32_MAX) || (full < I32_MIN); end
         3:  begin full = sa - sb; r = 32'(full); c = (full > I32_MAX) || (full < I32_MIN); end
         4:  begin full = ua + ub + longint'(m_scc); r = 32'(full); c = full > U32_MAX; end
         5:  begin full = ua - ub - longint'(m_scc); r = 32'(full); c = full < 0; end
         6:  begin c = sa <= sb; r = c ? a : b; end
         7:  begin c = ua <= ub; r = c ? a : b; end
         8:  begin c = sa >= sb; r = c ? a : b; end
         9:  begin c = ua >= ub; r = c ? a : b; end
         10: r = m_scc ? a : b;
         14: begin r = a & b; c = r != 32'd0; end
         16: begin r = a | b; c = r != 32'd0; end
         18: begin r = a ^ b; c = r != 32'd0; end
         30: begin r = a << b[4:0]; c = r != 32'd0; end
         32: begin r = a >> b[4:0]; c = r != 32'd0; end
         34: begin r = 32'(sa >>> b[4:0]); c = r != 32'd0; end
         36: r = 32'(sa * sb);
         default: legal = 1'b0;
      endcase
      if (ins[31:30] != 2'b10) legal = 1'b0;
      e.v = legal; e.ill = !legal; e.dest = 7'(dest); e.data = r; e.scc = c;
      if (legal) begin
         if (dest < NUM_SGPR) m_sgpr[dest] = r;
         m_scc = c;
      end
   endtask

   task automatic check_outputs(input exp_t e);
      chk("wb_valid", 32'(wb_valid), 32'(e.v));
      chk("illegal_instr", 32'(illegal_instr), 32'(e.ill));
      if (e.v) begin
         chk("wb_dest", 32'(wb_dest), 32'(e.dest));
         chk("wb_data", wb_data, e.data);
         chk("wb_scc", 32'(wb_scc), 32'(e.scc));
      end
   endtask

   // One clock: present an instruction, check the writeback of the previous accept.
   task automatic cycle(input logic v, input logic [31:0] ins);
      exp_t e;
      in_valid = v;
      in_data  = ins;
      @(posedge clk);
      #1;
      check_outputs(pend);
      if (v) model_exec(ins, e);
      else e = idle_exp();
      pend = e;
   endtask

   function automatic int rand_src();
      case ($urandom_range(0, 5))
         0, 1, 2: return int'($urandom_range(0, 11));
         3:       return int'($urandom_range(128, 192));
         4:       return int'($urandom_range(193, 208));
         default: return ($urandom_range(0, 1) == 0) ? 253 : int'($urandom_range(0, 255));
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [1:0] t;
      int         op, dest;
      t    = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      op   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127))
                                         : LEGAL_OPS[$urandom_range(0, 17)];
      dest = ($urandom_range(0, 9) == 0) ? int'($urandom_range(106, 127))
                                         : int'($urandom_range(0, 11));
      return enc(t, op, dest, rand_src(), rand_src());
   endfunction

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_dest", 32'(wb_dest), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_scc", 32'(wb_scc), 32'd0);
      chk("rst_illegal", 32'(illegal_instr), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", 32'(in_ready), 32'd1);
      repeat (10) cycle(1'b0, 32'd0);

      // s1 = s2 + s3
      cycle(1'b1, enc(2'b10, 0, 1, 3, 2));
      cycle(1'b0, 32'd0);
      chk("add_valid", 32'(wb_valid), 32'd1);
      chk("add_dest", 32'(wb_dest), 32'd1);
      chk("add_data", wb_data, 32'd5);
      chk("add_scc", 32'(wb_scc), 32'd0);
      cycle(1'b1, enc(2'b10, 16, 106, 128, 1));
      cycle(1'b0, 32'd0);
      chk("sgpr1_is_5", wb_data, 32'd5);

      // -1 + 1 carries out, then ADDC consumes the forwarded SCC
      cycle(1'b1, enc(2'b10, 0, 7, 129, 193));
      cycle(1'b1, enc(2'b10, 4, 8, 128, 128));
      chk("neg1_plus1_data", wb_data, 32'd0);
      chk("neg1_plus1_scc", 32'(wb_scc), 32'd1);
      cycle(1'b0, 32'd0);
      chk("addc_fwd_scc", wb_data, 32'd1);

      cycle(1'b1, enc(2'b10, 0, 1, 3, 2));
      cycle(1'b1, enc(2'b10, 0, 4, 1, 1));
      cycle(1'b0, 32'd0);
      chk("b2b_fwd_10", wb_data, 32'd10);
      cycle(1'b1, enc(2'b10, 0, 1, 2, 2));
      cycle(1'b1, enc(2'b10, 0, 4, 1, 1));
      cycle(1'b0, 32'd0);
      chk("b2b_fwd_8", wb_data, 32'd8);

      cycle(1'b1, enc(2'b10, 8, 9, 5, 193));
      cycle(1'b1, enc(2'b10, 9, 10, 5, 193));
      chk("max_i32_data", wb_data, 32'd5);
      chk("max_i32_scc", 32'(wb_scc), 32'd0);
      cycle(1'b0, 32'd0);
      chk("max_u32_data", wb_data, 32'hFFFF_FFFF);
      chk("max_u32_scc", 32'(wb_scc), 32'd1);

      cycle(1'b1, enc(2'b00, 0, 2, 3, 2));
      cycle(1'b1, enc(2'b10, 127, 2, 3, 2));
      chk("bad_type_illegal", 32'(illegal_instr), 32'd1);
      chk("bad_type_no_wb", 32'(wb_valid), 32'd0);
      cycle(1'b0, 32'd0);
      chk("bad_op_illegal", 32'(illegal_instr), 32'd1);
      cycle(1'b1, enc(2'b10, 16, 106, 128, 2));
      chk("illegal_one_pulse", 32'(illegal_instr), 32'd0);
      cycle(1'b0, 32'd0);
      chk("sgpr2_unchanged", wb_data, 32'd2);

      for (int n = 0; n < 600; n++) cycle($urandom_range(0, 3) != 0, rand_instr());
      cycle(1'b0, 32'd0);
      cycle(1'b0, 32'd0);

      // Reset lands while an instruction is in execute
      in_valid = 1'b1;
      in_data  = enc(2'b10, 0, 1, 129, 1);
      @(posedge clk);
      #1;
      check_outputs(pend);
      rst_n   = 1'b0;
      in_data = enc(2'b10, 0, 1, 130, 1);
      #1;
      chk("ready_low_in_rst", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_no_wb", 32'(wb_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_still_no_wb", 32'(wb_valid), 32'd0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      model_reset();
      cycle(1'b0, 32'd0);
      cycle(1'b1, enc(2'b10, 16, 106, 128, 1));
      cycle(1'b0, 32'd0);
      chk("sgpr1_after_rst", wb_data, 32'd1);
      cycle(1'b0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
